fpu_issue_ctrl: RTL and testbench

//  Issue/writeback scheduler for the FP execution units. Decode stage presents one exec_type op per cycle.

---
 rtl/fpu_issue_ctrl_pkg.sv | 38 +++
 rtl/fpu_wb_ring.sv | 94 +++++++++
 rtl/fpu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FP issue/writeback scheduler.
// Contents: exec_type opcode enum, default unit latencies, the writeback
// slot record fp_slot_t, and is_fp_op() which tells FP ops from the rest.
package fpu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ENop    = 4'd0,
    EAdd    = 4'd1,
    ESub    = 4'd2,
    ERshift = 4'd3,
    ELshift = 4'd4,
    EFadd   = 4'd5,
    EFsub   = 4'd6,
    EFmul   = 4'd7,
    EFdiv   = 4'd8,
    EFsqrt  = 4'd9,
    EFtoi   = 4'd10,
    EItof   = 4'd11
  } exec_type;

  localparam int FP_TAG_W      = 5;
  localparam int DEF_FADD_LAT  = 4;
  localparam int DEF_FMUL_LAT  = 3;
  localparam int DEF_FDIV_LAT  = 12;
  localparam int DEF_FSQRT_LAT = 16;
  localparam int DEF_CVT_LAT   = 2;

  typedef struct packed {
    logic                v;
    exec_type            op;
    logic [FP_TAG_W-1:0] tag;
  } fp_slot_t;

  function automatic logic is_fp_op(exec_type op);
    return op inside {EFadd, EFsub, EFmul, EFdiv, EFsqrt, EFtoi, EItof};
  endfunction

endpackage

// File: rtl/fpu_wb_ring.sv
// Latency-indexed writeback reservation ring.
// slot[k] holds the op whose result reaches the writeback port k cycles
// from now. The ring shifts toward slot[0] every cycle; a write overrides
// the shift for its slot. flush clears every slot at the clock edge.
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               clear all slots at the edge
//   wr_en/wr_idx        reserve slot wr_idx with {wr_op, wr_tag}
//   look_idx/look_busy  pre-shift occupancy of slot look_idx
//                       (indices >= MAX_LAT read as empty)
//   head_*              contents of slot[0] (writeback this cycle)
//   any_pending         some slot is occupied
module fpu_wb_ring
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int MAX_LAT = 16,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [4:0]       wr_idx,
  input  exec_type         wr_op,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [4:0]       look_idx,
  output logic             look_busy,
  output logic             head_v,
  output exec_type         head_op,
  output logic [TAG_W-1:0] head_tag,
  output logic             any_pending
);

  logic [MAX_LAT-1:0] v;
  exec_type           op  [MAX_LAT];
  logic [TAG_W-1:0]   tag [MAX_LAT];

  // One extra always-empty entry above the top slot, so the shift is
  // uniform for every k including the topmost.
  logic [MAX_LAT:0]   ext_v;
  exec_type           ext_op  [MAX_LAT+1];
  logic [TAG_W-1:0]   ext_tag [MAX_LAT+1];

  always_comb begin
    ext_v = {1'b0, v};
    for (int k = 0; k < MAX_LAT; k++) begin
      ext_op[k]  = op[k];
      ext_tag[k] = tag[k];
    end
    ext_op[MAX_LAT]  = ENop;
    ext_tag[MAX_LAT] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        v[k]   <= 1'b0;
        op[k]  <= ENop;
        tag[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        v[k]   <= 1'b0;
        op[k]  <= ENop;
        tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (wr_en && (wr_idx == 5'(k))) begin
          v[k]   <= 1'b1;
          op[k]  <= wr_op;
          tag[k] <= wr_tag;
        end else begin
          v[k]   <= ext_v[k+1];
          op[k]  <= ext_op[k+1];
          tag[k] <= ext_tag[k+1];
        end
      end
    end
  end

  always_comb begin
    look_busy = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (look_idx == 5'(k)) look_busy = v[k];
    end
  end

  assign head_v      = v[0];
  assign head_op     = op[0];
  assign head_tag    = tag[0];
  assign any_pending = |v;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue/writeback scheduler. Accepts one decoded op per cycle, pulses
// the matching unit start, and reserves the single FP writeback port in
// a latency-indexed ring so no two results land in the same cycle.
// Optional feature: define FPU_STALL_CNT_EN to add the 32-bit stall_cnt
// output (cycles with in_valid & !in_ready & !flush).
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid/in_ready          op handshake; in_ready depends on in_op
//   in_op, in_tag              exec_type and destination tag
//   flush                      kill everything in flight
//   start_add/add_sub          adder start, 0=add 1=sub
//   start_mul                  multiplier start
//   start_div/div_sqrt         div/sqrt start, 0=div 1=sqrt
//   start_cvt/cvt_dir          converter start, 0=ftoi 1=itof
//   wb_valid/wb_op/wb_tag      result due on the writeback port
//   busy                       slot pending or div/sqrt unit busy
//   illegal                    pulse after a non-FP op was consumed
//   stall_cnt                  only with FPU_STALL_CNT_EN
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int TAG_W     = FP_TAG_W,
  parameter int FADD_LAT  = DEF_FADD_LAT,
  parameter int FMUL_LAT  = DEF_FMUL_LAT,
  parameter int FDIV_LAT  = DEF_FDIV_LAT,
  parameter int FSQRT_LAT = DEF_FSQRT_LAT,
  parameter int CVT_LAT   = DEF_CVT_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  exec_type         in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             start_add,
  output logic             add_sub,
  output logic             start_mul,
  output logic             start_div,
  output logic             div_sqrt,
  output logic             start_cvt,
  output logic             cvt_dir,
  output logic             wb_valid,
  output exec_type         wb_op,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  output logic             illegal
`ifdef FPU_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int MAX_A   = (FADD_LAT > FMUL_LAT) ? FADD_LAT : FMUL_LAT;
  localparam int MAX_B   = (FDIV_LAT > FSQRT_LAT) ? FDIV_LAT : FSQRT_LAT;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_LAT = (MAX_AB > CVT_LAT) ? MAX_AB : CVT_LAT;

  logic       fp_op;
  logic       is_divsqrt;
  logic [4:0] op_lat;
  logic       look_busy;
  logic       accept;
  logic       any_pending;
  logic [4:0] div_cnt;

  assign fp_op      = is_fp_op(in_op);
  assign is_divsqrt = (in_op == EFdiv) || (in_op == EFsqrt);

  always_comb begin
    case (in_op)
      EFadd, EFsub: op_lat = 5'(FADD_LAT);
      EFmul:        op_lat = 5'(FMUL_LAT);
      EFdiv:        op_lat = 5'(FDIV_LAT);
      EFsqrt:       op_lat = 5'(FSQRT_LAT);
      EFtoi, EItof: op_lat = 5'(CVT_LAT);
      default:      op_lat = 5'd1;
    endcase
  end

  // Non-FP ops are simply consumed; FP ops need their writeback slot free
  // and, for div/sqrt, the iterative unit idle. flush blocks everything.
  always_comb begin
    in_ready = 1'b0;
    if (in_valid && !flush) begin
      if (!fp_op) in_ready = 1'b1;
      else        in_ready = !look_busy && !(is_divsqrt && (div_cnt != 5'd0));
    end
    accept = in_ready && fp_op;
  end

  fpu_wb_ring #(
    .MAX_LAT (MAX_LAT),
    .TAG_W   (TAG_W)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (accept),
    .wr_idx      (op_lat - 5'd1),
    .wr_op       (in_op),
    .wr_tag      (in_tag),
    .look_idx    (op_lat),
    .look_busy   (look_busy),
    .head_v      (wb_valid),
    .head_op     (wb_op),
    .head_tag    (wb_tag),
    .any_pending (any_pending)
  );

  // The shared div/sqrt unit is non-pipelined: hold off the next
  // div/sqrt until L cycles after the previous accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      div_cnt <= 5'd0;
    else if (flush)               div_cnt <= 5'd0;
    else if (accept && is_divsqrt) div_cnt <= op_lat - 5'd1;
    else if (div_cnt != 5'd0)     div_cnt <= div_cnt - 5'd1;
  end

  // Start pulses and qualifiers are registered one cycle after accept;
  // qualifiers are only meaningful alongside their start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_add <= 1'b0;
      add_sub   <= 1'b0;
      start_mul <= 1'b0;
      start_div <= 1'b0;
      div_sqrt  <= 1'b0;
      start_cvt <= 1'b0;
      cvt_dir   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      start_add <= accept && ((in_op == EFadd) || (in_op == EFsub));
      add_sub   <= accept && (in_op == EFsub);
      start_mul <= accept && (in_op == EFmul);
      start_div <= accept && is_divsqrt;
      div_sqrt  <= accept && (in_op == EFsqrt);
      start_cvt <= accept && ((in_op == EFtoi) || (in_op == EItof));
      cvt_dir   <= accept && (in_op == EItof);
      illegal   <= in_ready && !fp_op;
    end
  end

  assign busy = any_pending || (div_cnt != 5'd0);

`ifdef FPU_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               stall_cnt <= 32'd0;
    else if (in_valid && !in_ready && !flush) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns
// after the edge. With FPU_STALL_CNT_EN defined the stall counter is
// checked as well.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  exec_type   in_op;
  logic [4:0] in_tag;
  logic       flush;
  logic       start_add, add_sub, start_mul, start_div, div_sqrt;
  logic       start_cvt, cvt_dir;
  logic       wb_valid;
  exec_type   wb_op;
  logic [4:0] wb_tag;
  logic       busy;
  logic       illegal;
`ifdef FPU_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int num_checks = 0;
  int num_pass   = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .flush     (flush),
    .start_add (start_add),
    .add_sub   (add_sub),
    .start_mul (start_mul),
    .start_div (start_div),
    .div_sqrt  (div_sqrt),
    .start_cvt (start_cvt),
    .cvt_dir   (cvt_dir),
    .wb_valid  (wb_valid),
    .wb_op     (wb_op),
    .wb_tag    (wb_tag),
    .busy      (busy),
    .illegal   (illegal)
`ifdef FPU_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs === exp) num_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [4:0] tag,
                               input logic fl);
    in_valid = v;
    in_op    = exec_type'(op);
    in_tag   = tag;
    flush    = fl;
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, ENop, 5'd0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = ENop; in_tag = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_op", 32'(wb_op), 32'(ENop));
    checkOutput("rst_wb_tag", 32'(wb_tag), 32'd0);
    checkOutput("rst_busy_illegal", 32'({busy, illegal}), 32'd0);
    checkOutput("rst_starts", 32'({start_add, add_sub, start_mul, start_div, div_sqrt,
                                   start_cvt, cvt_dir}), 32'd0);
`ifdef FPU_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    nextCycle();

    // Scenario 1: single fadd, latency 4
    applyStimulus(1'b1, EFadd, 5'd3, 1'b0);
    checkOutput("s1_ready", 32'(in_ready), 32'd1);
    nextCycle();
    idle();
    checkOutput("s1_start_add", 32'(start_add), 32'd1);
    checkOutput("s1_add_sub", 32'(add_sub), 32'd0);
    checkOutput("s1_start_mul", 32'(start_mul), 32'd0);
    checkOutput("s1_busy", 32'(busy), 32'd1);
    nextCycle();
    idle(); nextCycle();
    idle();
    checkOutput("s1_wb_early", 32'(wb_valid), 32'd0);
    nextCycle();
    idle();
    checkOutput("s1_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("s1_wb_tag", 32'(wb_tag), 32'd3);
    checkOutput("s1_wb_op", 32'(wb_op), 32'(EFadd));
    nextCycle();
    idle();
    checkOutput("s1_wb_done", 32'(wb_valid), 32'd0);
    checkOutput("s1_idle_busy", 32'(busy), 32'd0);
    nextCycle();

    // Scenario 2: fadd t0 (wb t4) blocks fmul at t1 (also wb t4)
    applyStimulus(1'b1, EFadd, 5'd1, 1'b0);
    checkOutput("s2_add_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, EFmul, 5'd2, 1'b0);
    checkOutput("s2_mul_conflict", 32'(in_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b1, EFmul, 5'd2, 1'b0);
    checkOutput("s2_mul_ready", 32'(in_ready), 32'd1);
    nextCycle();
    idle();
    checkOutput("s2_start_mul", 32'(start_mul), 32'd1);
    checkOutput("s2_wb_t3", 32'(wb_valid), 32'd0);
    nextCycle();
    idle();
    checkOutput("s2_wb_add", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFadd, 5'd1}));
    nextCycle();
    idle();
    checkOutput("s2_wb_mul", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFmul, 5'd2}));
    nextCycle();
    idle(); nextCycle();

    // Scenario 3: fdiv t0, fsqrt stalled until div_cnt reaches 0 at t12
    applyStimulus(1'b1, EFdiv, 5'd4, 1'b0);
    checkOutput("s3_div_ready", 32'(in_ready), 32'd1);
    nextCycle();
    seen = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(1'b1, EFsqrt, 5'd5, 1'b0);
      if (i == 1) begin
        checkOutput("s3_start_div", 32'(start_div), 32'd1);
        checkOutput("s3_div_sqrt0", 32'(div_sqrt), 32'd0);
      end
      seen = seen | in_ready;
      nextCycle();
    end
    checkOutput("s3_sqrt_stalled", 32'(seen), 32'd0);
    applyStimulus(1'b1, EFsqrt, 5'd5, 1'b0);
    checkOutput("s3_sqrt_ready_t12", 32'(in_ready), 32'd1);
    checkOutput("s3_wb_div", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFdiv, 5'd4}));
`ifdef FPU_STALL_CNT_EN
    // One stall from the conflict scenario plus eleven here.
    checkOutput("s3_stall_cnt", stall_cnt, 32'd12);
`endif
    nextCycle();
    idle();
    checkOutput("s3_start_sqrt", 32'({start_div, div_sqrt}), 32'b11);
    nextCycle();
    seen = 1'b0;
    for (int i = 14; i <= 27; i++) begin
      idle();
      seen = seen | wb_valid;
      nextCycle();
    end
    checkOutput("s3_no_early_wb", 32'(seen), 32'd0);
    idle();
    checkOutput("s3_wb_sqrt", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFsqrt, 5'd5}));
    nextCycle();
    idle();
    checkOutput("s3_idle_busy", 32'(busy), 32'd0);
    nextCycle();

    // Scenario 4: fsub t0, flush t2, new ftoi t3
    applyStimulus(1'b1, EFsub, 5'd7, 1'b0);
    checkOutput("s4_sub_ready", 32'(in_ready), 32'd1);
    nextCycle();
    idle();
    checkOutput("s4_start_sub", 32'({start_add, add_sub}), 32'b11);
    nextCycle();
    applyStimulus(1'b1, EFadd, 5'd8, 1'b1);
    checkOutput("s4_flush_ready", 32'(in_ready), 32'd0);
    checkOutput("s4_busy_pre", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(1'b1, EFtoi, 5'd9, 1'b0);
    checkOutput("s4_busy_post", 32'(busy), 32'd0);
    checkOutput("s4_no_start", 32'(start_add), 32'd0);
    checkOutput("s4_ready_t3", 32'(in_ready), 32'd1);
    nextCycle();
    idle();
    checkOutput("s4_killed_wb", 32'(wb_valid), 32'd0);
    checkOutput("s4_start_cvt", 32'({start_cvt, cvt_dir}), 32'b10);
    nextCycle();
    idle();
    checkOutput("s4_wb_cvt", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFtoi, 5'd9}));
    nextCycle();

    // Scenario 5: non-FP ops are consumed and flagged
    applyStimulus(1'b1, EAdd, 5'd1, 1'b0);
    checkOutput("s5_eadd_ready", 32'(in_ready), 32'd1);
    nextCycle();
    idle();
    checkOutput("s5_illegal", 32'(illegal), 32'd1);
    checkOutput("s5_no_starts", 32'({start_add, start_mul, start_div, start_cvt}), 32'd0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 4'hC, 5'd2, 1'b0);
    checkOutput("s5_code_c_ready", 32'(in_ready), 32'd1);
    checkOutput("s5_illegal_pulse", 32'(illegal), 32'd0);
    nextCycle();
    idle();
    checkOutput("s5_illegal_c", 32'(illegal), 32'd1);
    nextCycle();
    idle();
    checkOutput("s5_no_wb", 32'({wb_valid, busy, illegal}), 32'd0);
    nextCycle();

    // Scenario 6: async reset with several ops in flight
    applyStimulus(1'b1, EFmul, 5'd11, 1'b0);
    checkOutput("s6_mul_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, EFadd, 5'd10, 1'b0);
    checkOutput("s6_add_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, EItof, 5'd12, 1'b0);
    checkOutput("s6_itof_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, EFdiv, 5'd13, 1'b0);
    checkOutput("s6_div_ready", 32'(in_ready), 32'd1);
    checkOutput("s6_start_itof", 32'({start_cvt, cvt_dir}), 32'b11);
    checkOutput("s6_wb_mul", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFmul, 5'd11}));
    nextCycle();
    idle();
    checkOutput("s6_start_div", 32'(start_div), 32'd1);
    checkOutput("s6_wb_itof", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EItof, 5'd12}));
    nextCycle();
    idle();
    checkOutput("s6_wb_add", 32'({wb_valid, wb_op, wb_tag}), 32'({1'b1, EFadd, 5'd10}));
    checkOutput("s6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("s6_rst_wb", 32'({wb_valid, wb_op, wb_tag}), 32'd0);
    checkOutput("s6_rst_busy", 32'({busy, illegal, start_div}), 32'd0);
`ifdef FPU_STALL_CNT_EN
    checkOutput("s6_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    nextCycle();
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      idle();
      seen = seen | wb_valid | busy;
      nextCycle();
    end
    checkOutput("s6_quiet_after_rst", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
